// File: rtl/iter_mult_pkg.sv
// ---------------------------------------------------------------------------
// iter_mult_pkg : shared FSM states and sizing for the iterative multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iter_mult_pkg;

    localparam int ITERATIONS = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_mult_wb_if.sv
// ---------------------------------------------------------------------------
// iter_mult_wb_if : issue and register-file write-port bundle of the multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface iter_mult_wb_if #(
    parameter int WIDTH = 32
);
    import iter_mult_pkg::*;

    logic                  start;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      write_data;
    logic [REG_ADDR_W-1:0] write_register;
    logic                  reg_write;
    logic [WIDTH-1:0]      hi;

    modport master (
        output start, operand_a, operand_b, dest_reg,
        input  busy, done, write_data, write_register, reg_write, hi
    );

    modport slave (
        input  start, operand_a, operand_b, dest_reg,
        output busy, done, write_data, write_register, reg_write, hi
    );

endinterface

`default_nettype wire

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath : shift-add accumulator, adder and shifter driven by load/step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_datapath
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 load,
    input  wire logic                 step,
    input  wire logic [WIDTH-1:0]     a,
    input  wire logic [WIDTH-1:0]     b,
    output logic      [2*WIDTH-1:0]   product_next,
    output logic      [CNT_W-1:0]     count
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     sum;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum          = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        product_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= product_next;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/iter_mult_wb.sv
// ---------------------------------------------------------------------------
// iter_mult_wb : 32-step unsigned multiplier with register-file write-back
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_mult_wb
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    iter_mult_wb_if.slave bus
);

    state_t                state;
    state_t                state_next;
    logic                  load;
    logic                  step;
    logic                  finish;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [REG_ADDR_W-1:0] write_register;
    logic [WIDTH-1:0]      write_data;
    logic [WIDTH-1:0]      hi;
    logic [2*WIDTH-1:0]    product_next;
    logic [CNT_W-1:0]      count;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .a            (bus.operand_a),
        .b            (bus.operand_b),
        .product_next (product_next),
        .count        (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last step and the WB entry share one edge, so the result is
    // captured from the datapath's combinational next value.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CNT_W'(ITERATIONS - 1)) begin
                    finish     = 1'b1;
                    state_next = WB;
                end
            end
            WB: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q         <= '0;
            write_data     <= '0;
            hi             <= '0;
            write_register <= '0;
        end else begin
            if (load) begin
                dest_q <= bus.dest_reg;
            end
            if (finish) begin
                write_data     <= product_next[WIDTH-1:0];
                hi             <= product_next[2*WIDTH-1:WIDTH];
                write_register <= dest_q;
            end
        end
    end

    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == WB);
    assign bus.reg_write      = (state == WB) && (write_register != '0);
    assign bus.write_data     = write_data;
    assign bus.write_register = write_register;
    assign bus.hi             = hi;

endmodule

`default_nettype wire

// File: tb/tb_iter_mult_wb.sv
// ---------------------------------------------------------------------------
// tb_iter_mult_wb : directed self-checking bench for iter_mult_wb
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iter_mult_wb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] rf [0:31];

    iter_mult_wb_if #(.WIDTH(32)) bus ();

    iter_mult_wb #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed straight from the write port
    always @(posedge clk) begin
        if (bus.reg_write) rf[bus.write_register] <= bus.write_data;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_reg  = d;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h1234_5678;
        bus.dest_reg  = 5'd31;
    endtask

    // Samples from the negedge issue() leaves us on; cycle 1 = first after accept.
    task automatic wait_done(output int cyc, output int busy_n, output int rw_n);
        cyc = 0; busy_n = 0; rw_n = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.reg_write) rw_n++;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc == 0) begin
            failures++;
            $display("FAIL done_timeout got=none exp=done within 100 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.reg_write} !== 3'b000 || bus.write_data !== 32'd0 ||
            bus.hi !== 32'd0 || bus.write_register !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h/%h/%h exp=000/0/0/0",
                     {bus.busy, bus.done, bus.reg_write}, bus.write_data, bus.hi, bus.write_register);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, bn, rn;
        issue(32'd6, 32'd7, 5'd2);
        wait_done(cyc, bn, rn);
        checks++;
        if (cyc !== 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", cyc); end
        checks++;
        if (bn !== 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", bn); end
        checks++;
        if (rn !== 1 || bus.reg_write !== 1'b1) begin
            failures++; $display("FAIL basic_regwrite got=%0d exp=1", rn);
        end
        checks++;
        if (bus.write_data !== 32'd42 || bus.write_register !== 5'd2 || bus.hi !== 32'd0) begin
            failures++;
            $display("FAIL basic_result got=%h/%h/%h exp=0000002a/02/00000000",
                     bus.write_data, bus.write_register, bus.hi);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.reg_write} !== 3'b000 || bus.write_data !== 32'd42) begin
            failures++;
            $display("FAIL basic_after_wb got=%b/%h exp=000/0000002a",
                     {bus.busy, bus.done, bus.reg_write}, bus.write_data);
        end
        checks++;
        if (rf[2] !== 32'd42) begin failures++; $display("FAIL basic_rf_read got=%h exp=0000002a", rf[2]); end
    endtask

    task automatic test_max();
        int cyc, bn, rn;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        wait_done(cyc, bn, rn);
        checks++;
        if (bus.write_data !== 32'h0000_0001 || bus.hi !== 32'hFFFF_FFFE || bus.write_register !== 5'd5) begin
            failures++;
            $display("FAIL max_result got=%h/%h/%h exp=00000001/fffffffe/05",
                     bus.write_data, bus.hi, bus.write_register);
        end
    endtask

    task automatic test_reset_abort();
        int rn;
        issue(32'd6, 32'd7, 5'd4);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.reg_write} !== 3'b000 || bus.write_data !== 32'd0 ||
            bus.hi !== 32'd0 || bus.write_register !== 5'd0) begin
            failures++;
            $display("FAIL abort_outputs got=%b/%h/%h/%h exp=000/0/0/0",
                     {bus.busy, bus.done, bus.reg_write}, bus.write_data, bus.hi, bus.write_register);
        end
        @(negedge clk);
        rst = 1'b0;
        rn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.reg_write || bus.done || bus.busy) rn++;
        end
        checks++;
        if (rn !== 0 || rf[4] !== 32'd0) begin
            failures++; $display("FAIL abort_no_write got=%0d/%h exp=0/00000000", rn, rf[4]);
        end
        test_after_abort();
    endtask

    task automatic test_after_abort();
        int cyc, bn, rn;
        issue(32'd2, 32'd21, 5'd6);
        wait_done(cyc, bn, rn);
        checks++;
        if (cyc !== 33 || bus.write_data !== 32'd42 || bus.hi !== 32'd0 || rn !== 1) begin
            failures++;
            $display("FAIL after_abort got=%0d/%h/%h/%0d exp=33/0000002a/00000000/1",
                     cyc, bus.write_data, bus.hi, rn);
        end
    endtask

    task automatic test_restart_ignored();
        int cyc, bn, rn, extra;
        issue(32'd6, 32'd7, 5'd3);
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd1; bus.operand_b = 32'd1; bus.dest_reg = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, bn, rn);
        checks++;
        if (bus.write_data !== 32'd42 || bus.write_register !== 5'd3 || rn !== 1) begin
            failures++;
            $display("FAIL restart_result got=%h/%h/%0d exp=0000002a/03/1",
                     bus.write_data, bus.write_register, rn);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra !== 0 || rf[7] !== 32'd0) begin
            failures++; $display("FAIL restart_second_op got=%0d/%h exp=0/00000000", extra, rf[7]);
        end
    endtask

    task automatic test_dest_zero();
        int cyc, bn, rn;
        issue(32'd3, 32'd5, 5'd0);
        wait_done(cyc, bn, rn);
        checks++;
        if (bus.done !== 1'b1 || rn !== 0 || bus.write_data !== 32'd15 || bus.write_register !== 5'd0) begin
            failures++;
            $display("FAIL dest_zero got=%b/%0d/%h/%h exp=1/0/0000000f/00",
                     bus.done, rn, bus.write_data, bus.write_register);
        end
        @(negedge clk);
        checks++;
        if (rf[0] !== 32'd0) begin failures++; $display("FAIL dest_zero_rf0 got=%h exp=00000000", rf[0]); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, ndone, nrw;
        logic [31:0] wd1, wd2;
        d1 = 0; d2 = 0; ndone = 0; nrw = 0; wd1 = '0; wd2 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd10; bus.operand_b = 32'd10; bus.dest_reg = 5'd9;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (bus.reg_write) nrw++;
            if (bus.done) begin
                ndone++;
                if (d1 == 0) begin d1 = i; wd1 = bus.write_data; end
                else begin d2 = i; wd2 = bus.write_data; end
            end
            if (i == 67) bus.start = 1'b0;
        end
        checks++;
        if (d1 !== 33 || d2 !== 67 || ndone !== 2) begin
            failures++; $display("FAIL b2b_timing got=%0d/%0d/%0d exp=33/67/2", d1, d2, ndone);
        end
        checks++;
        if (wd1 !== 32'd100 || wd2 !== 32'd100 || nrw !== 2) begin
            failures++; $display("FAIL b2b_data got=%h/%h/%0d exp=00000064/00000064/2", wd1, wd2, nrw);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_basic();
        test_max();
        test_reset_abort();
        test_restart_ignored();
        test_dest_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
